// File: rtl/aes_key_expand_seq.sv
// ---------------------------------------------------------------------------
// aes_key_expand_seq
//
// Purpose:
//   Sequential AES-128 key schedule. A 128-bit cipher key is taken in through
//   a valid/ready handshake and the 11 round keys are produced one per cycle
//   into local storage. Storage is visible both as a flat bus and through an
//   indexed combinational read port, and feeds the round datapath directly.
//
// Ports:
//   clk        in   1     rising-edge clock
//   rst_n      in   1     synchronous active-low reset
//   key_valid  in   1     key_in carries a key this cycle
//   key_ready  out  1     block accepts a key this cycle (IDLE only)
//   key_in     in   128   cipher key, bit 127 = first FIPS-197 byte
//   rk_idx     in   4     round key select for rk_out
//   rk_out     out  128   round key rk_idx (0 for indices 11..15)
//   rk_flat    out  1408  rk_flat[128*i +: 128] = round key i
//   keys_valid out  1     all 11 round keys belong to the last accepted key
//   busy       out  1     expansion in progress
//
// Configuration:
//   AES_KEYEXP_ZEROIZE_EN  when defined, round keys 1..10 are cleared on key
//                          acceptance so that keys not yet computed read 0.
// ---------------------------------------------------------------------------

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

module aes_key_expand_seq (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_valid,
    output logic            key_ready,
    input  logic [127:0]    key_in,
    input  logic [3:0]      rk_idx,
    output logic [127:0]    rk_out,
    output logic [1407:0]   rk_flat,
    output logic            keys_valid,
    output logic            busy
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   rk_q [0:10];
    logic [127:0]   rk_d [0:10];
    logic           keys_valid_q, keys_valid_d;
    logic           key_ready_q, key_ready_d;
    logic           busy_q, busy_d;

    logic [127:0]   prev_key;
    logic [127:0]   next_key;
    logic [7:0]     rcon;
    logic [31:0]    rot_word;
    logic [31:0]    sub_word;
    logic [31:0]    t_word;
    logic [31:0]    nw0, nw1, nw2, nw3;

    // Round rnd derives from the key stored one slot below it.
    always_comb begin
        prev_key = '0;
        for (int i = 0; i < 10; i++) begin
            if (rnd_q == 4'(i + 1)) begin
                prev_key = rk_q[i];
            end
        end
    end

    always_comb begin
        case (rnd_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord of w3 (the low word) moves its top byte to the bottom.
    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*g +: 8]),
            .out_byte (sub_word[8*g +: 8])
        );
    end

    assign t_word   = sub_word ^ {rcon, 24'h0};
    assign nw0      = prev_key[127:96] ^ t_word;
    assign nw1      = prev_key[95:64]  ^ nw0;
    assign nw2      = prev_key[63:32]  ^ nw1;
    assign nw3      = prev_key[31:0]   ^ nw2;
    assign next_key = {nw0, nw1, nw2, nw3};

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        keys_valid_d = keys_valid_q;
        key_ready_d  = key_ready_q;
        busy_d       = busy_q;
        for (int i = 0; i <= 10; i++) begin
            rk_d[i] = rk_q[i];
        end

        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    rk_d[0]      = key_in;
`ifdef AES_KEYEXP_ZEROIZE_EN
                    for (int i = 1; i <= 10; i++) begin
                        rk_d[i] = '0;
                    end
`else
                    // Older round keys stay in place until overwritten.
`endif
                    rnd_d        = 4'd1;
                    keys_valid_d = 1'b0;
                    key_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = EXPAND;
                end
            end
            EXPAND: begin
                for (int i = 1; i <= 10; i++) begin
                    if (rnd_q == 4'(i)) begin
                        rk_d[i] = next_key;
                    end
                end
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd10) begin
                    rnd_d        = 4'd0;
                    keys_valid_d = 1'b1;
                    key_ready_d  = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rnd_q        <= 4'd0;
            keys_valid_q <= 1'b0;
            key_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            for (int i = 0; i <= 10; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            keys_valid_q <= keys_valid_d;
            key_ready_q  <= key_ready_d;
            busy_q       <= busy_d;
            for (int i = 0; i <= 10; i++) begin
                rk_q[i] <= rk_d[i];
            end
        end
    end

    assign key_ready  = key_ready_q;
    assign busy       = busy_q;
    assign keys_valid = keys_valid_q;

    // Indices 11..15 fall through to zero.
    always_comb begin
        rk_out = '0;
        for (int i = 0; i <= 10; i++) begin
            if (rk_idx == 4'(i)) begin
                rk_out = rk_q[i];
            end
        end
    end

    always_comb begin
        rk_flat = '0;
        for (int i = 0; i <= 10; i++) begin
            rk_flat[128*i +: 128] = rk_q[i];
        end
    end

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand_seq
//
// Self-checking bench for aes_key_expand_seq. A behavioural model derives
// the AES-128 key schedule from GF(2^8) arithmetic and tracks which round
// keys must be visible after each edge; a compare process checks every
// output against it each cycle. Directed vectors add literal FIPS-197 values.
// Honours AES_KEYEXP_ZEROIZE_EN the same way the design does.
// ---------------------------------------------------------------------------

module tb_aes_key_expand_seq;

    logic            clk;
    logic            rst_n;
    logic            key_valid;
    logic            key_ready;
    logic [127:0]    key_in;
    logic [3:0]      rk_idx;
    logic [127:0]    rk_out;
    logic [1407:0]   rk_flat;
    logic            keys_valid;
    logic            busy;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_expand_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .rk_flat    (rk_flat),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b  = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] dbl;
        dbl = {v, v} << n;
        return dbl[15:8];
    endfunction

    // S-box from first principles: multiplicative inverse then affine map.
    function automatic logic [7:0] sboxModel(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // Word-oriented FIPS-197 expansion into all 11 round keys.
    function automatic logic [1407:0] expandFlat(input logic [127:0] key);
        logic [31:0]   w [0:43];
        logic [31:0]   temp;
        logic [7:0]    rc;
        logic [1407:0] flat;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sboxModel(temp[31:24]), sboxModel(temp[23:16]),
                        sboxModel(temp[15:8]),  sboxModel(temp[7:0])};
                temp = temp ^ {rc, 24'h0};
                rc   = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) begin
            flat[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return flat;
    endfunction

    // Model of storage visibility: slot i of the accepted key appears i edges
    // after acceptance; m_cnt counts edges since acceptance (0 = idle).
    logic [1407:0] m_flat;
    logic [1407:0] m_exp;
    int            m_cnt = 0;
    logic          m_kv  = 1'b0;
    logic          armed = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_flat = '0;
                m_cnt  = 0;
                m_kv   = 1'b0;
            end else if (m_cnt == 0) begin
                if (key_valid) begin
                    m_exp          = expandFlat(key_in);
                    m_flat[127:0]  = key_in;
`ifdef AES_KEYEXP_ZEROIZE_EN
                    m_flat[1407:128] = '0;
`endif
                    m_kv  = 1'b0;
                    m_cnt = 1;
                end
            end else begin
                m_flat[128*m_cnt +: 128] = m_exp[128*m_cnt +: 128];
                if (m_cnt == 10) begin
                    m_cnt = 0;
                    m_kv  = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            armed = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every cycle, after the edge has settled, compare all outputs to the model.
    initial begin
        int idx;
        forever begin
            @(posedge clk);
            #2;
            if (armed) begin
                for (int r = 0; r < 11; r++) begin
                    checkOutput($sformatf("cyc rk_flat[%0d]", r), rk_flat[128*r +: 128], m_flat[128*r +: 128]);
                end
                checkOutput("cyc keys_valid", {127'b0, keys_valid}, {127'b0, m_kv});
                checkOutput("cyc key_ready", {127'b0, key_ready}, {127'b0, (m_cnt == 0)});
                checkOutput("cyc busy", {127'b0, busy}, {127'b0, (m_cnt != 0)});
                idx = int'(rk_idx);
                checkOutput("cyc rk_out", rk_out, (idx <= 10) ? m_flat[128*idx +: 128] : 128'h0);
            end
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer a key for one cycle starting at a falling edge; returns after the
    // accepting rising edge, at the following falling edge.
    task automatic applyStimulus(input logic [127:0] key);
        key_valid = 1'b1;
        key_in    = key;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic readRk(input logic [3:0] idx, output logic [127:0] val);
        rk_idx = idx;
        #1;
        val = rk_out;
    endtask

    initial begin
        logic [127:0]  v;
        logic [1407:0] a_keys;

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_idx    = 4'd0;

        // Reset state.
        waitEdges(2);
        for (int r = 0; r < 11; r++) begin
            checkOutput($sformatf("reset rk%0d", r), rk_flat[128*r +: 128], 128'h0);
        end
        checkOutput("reset keys_valid", {127'b0, keys_valid}, 128'h0);
        checkOutput("reset key_ready", {127'b0, key_ready}, 128'h1);
        checkOutput("reset busy", {127'b0, busy}, 128'h0);
        checkOutput("reset rk_out", rk_out, 128'h0);
        rst_n = 1'b1;

        // Model pinned against published FIPS-197 values.
        a_keys = expandFlat(KEY_FIPS);
        checkOutput("model fips rk1", a_keys[128 +: 128], FIPS_RK1);
        checkOutput("model fips rk10", a_keys[1280 +: 128], FIPS_RK10);

        // Basic expansion.
        $display("[TB] basic expansion");
        applyStimulus(KEY_FIPS);
        checkOutput("basic busy@N", {127'b0, busy}, 128'h1);
        waitEdges(9);
        checkOutput("basic keys_valid@N+9", {127'b0, keys_valid}, 128'h0);
        waitEdges(1);
        checkOutput("basic keys_valid@N+10", {127'b0, keys_valid}, 128'h1);
        checkOutput("basic key_ready@N+10", {127'b0, key_ready}, 128'h1);
        readRk(4'd1, v);
        checkOutput("basic rk1", v, FIPS_RK1);
        readRk(4'd10, v);
        checkOutput("basic rk10", v, FIPS_RK10);

        // Re-key with the zero key; rk7 read while expansion is early.
        $display("[TB] zero key re-key");
        applyStimulus(128'h0);
        checkOutput("rekey keys_valid drop", {127'b0, keys_valid}, 128'h0);
        waitEdges(3);
        readRk(4'd7, v);
`ifdef AES_KEYEXP_ZEROIZE_EN
        checkOutput("rekey rk7@N+3", v, 128'h0);
`else
        checkOutput("rekey rk7@N+3", v, a_keys[128*7 +: 128]);
`endif
        waitEdges(7);
        checkOutput("zero keys_valid", {127'b0, keys_valid}, 128'h1);
        readRk(4'd0, v);
        checkOutput("zero rk0", v, 128'h0);
        readRk(4'd1, v);
        checkOutput("zero rk1", v, ZERO_RK1);
        readRk(4'd10, v);
        checkOutput("zero rk10", v, ZERO_RK10);
        readRk(4'd12, v);
        checkOutput("zero rk_idx12", v, 128'h0);
        readRk(4'd15, v);
        checkOutput("zero rk_idx15", v, 128'h0);

        // Handshake: a second key held during EXPAND must wait.
        $display("[TB] handshake");
        applyStimulus(KEY_FIPS);
        key_valid = 1'b1;
        key_in    = KEY_SEQ;
        waitEdges(9);
        checkOutput("hs key_ready@N+9", {127'b0, key_ready}, 128'h0);
        readRk(4'd0, v);
        checkOutput("hs rk0 unchanged", v, KEY_FIPS);
        waitEdges(1);
        checkOutput("hs keys_valid@N+10", {127'b0, keys_valid}, 128'h1);
        readRk(4'd10, v);
        checkOutput("hs rk10", v, FIPS_RK10);
        waitEdges(1);
        key_valid = 1'b0;
        checkOutput("hs keys_valid@N+11", {127'b0, keys_valid}, 128'h0);
        readRk(4'd0, v);
        checkOutput("hs rk0 new key", v, KEY_SEQ);
        waitEdges(10);
        checkOutput("hs second keys_valid", {127'b0, keys_valid}, 128'h1);
        readRk(4'd10, v);
        checkOutput("hs second rk10", v, SEQ_RK10);

        // Reset mid-expansion with a key offered during the reset cycle.
        $display("[TB] reset mid-operation");
        applyStimulus(KEY_SEQ);
        waitEdges(4);
        rst_n     = 1'b0;
        key_valid = 1'b1;
        key_in    = KEY_FIPS;
        waitEdges(1);
        key_valid = 1'b0;
        for (int r = 0; r < 11; r++) begin
            checkOutput($sformatf("midrst rk%0d", r), rk_flat[128*r +: 128], 128'h0);
        end
        checkOutput("midrst keys_valid", {127'b0, keys_valid}, 128'h0);
        checkOutput("midrst key_ready", {127'b0, key_ready}, 128'h1);
        checkOutput("midrst busy", {127'b0, busy}, 128'h0);
        rst_n = 1'b1;
        applyStimulus(KEY_FIPS);
        waitEdges(10);
        checkOutput("fresh keys_valid", {127'b0, keys_valid}, 128'h1);
        readRk(4'd1, v);
        checkOutput("fresh rk1", v, FIPS_RK1);
        readRk(4'd10, v);
        checkOutput("fresh rk10", v, FIPS_RK10);

        waitEdges(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
